// File: rtl/uart_io_fifo.sv
// Memory-mapped UART port with a TX FIFO and an RX FIFO; status keeps the legacy control word layout.
// Optional: define UART_IO_FIFO_LOOPBACK_EN to add a loopback port that routes TX bytes into the RX FIFO.

module uart_io_fifo_q #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [7:0]  push_data,
    input  logic        pop,
    output logic [7:0]  head,
    output logic [AW:0] count
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    // Fullness/emptiness come from the registered count, so a push into a
    // full queue is dropped even when a pop frees a slot in the same cycle.
    assign wr_en = push && (count != FULL);
    assign rd_en = pop && (count != '0);

    // Head reads as zero while empty so stale storage never leaks out after reset.
    assign head = (count != '0) ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end
endmodule

module uart_io_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
`ifdef UART_IO_FIFO_LOOPBACK_EN
    input  logic        loopback,
`endif
    input  logic        tx_push,
    input  logic [7:0]  tx_data,
    input  logic        rx_pop,
    output logic [7:0]  rx_data,
    output logic [31:0] status,
    input  logic        clear_flags,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [AW:0] tx_count;
    logic [AW:0] rx_count;
    logic [7:0]  tx_head;
    logic [7:0]  rx_push_data;
    logic        tx_pop;
    logic        rx_push;
    logic        lb_on;
    logic        lb_move;
    logic        tx_overflow;
    logic        rx_underflow;

`ifdef UART_IO_FIFO_LOOPBACK_EN
    assign lb_on = loopback;
`else
    assign lb_on = 1'b0;
`endif

    // Loopback moves the TX head straight into RX; the uart handshakes are
    // masked so a byte can only take one path in any cycle.
    assign lb_move       = lb_on && (tx_count != '0) && (rx_count != FULL);
    assign uart_tx_valid = !lb_on && (tx_count != '0);
    assign uart_tx_data  = tx_head;
    assign uart_rx_ready = !lb_on && (rx_count != FULL);

    assign tx_pop       = (uart_tx_valid && uart_tx_ready) || lb_move;
    assign rx_push      = (uart_rx_valid && uart_rx_ready) || lb_move;
    assign rx_push_data = lb_move ? tx_head : uart_rx_data;

    uart_io_fifo_q #(.DEPTH(DEPTH), .AW(AW)) u_tx_q (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (tx_data),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count)
    );

    uart_io_fifo_q #(.DEPTH(DEPTH), .AW(AW)) u_rx_q (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_push),
        .push_data (rx_push_data),
        .pop       (rx_pop),
        .head      (rx_data),
        .count     (rx_count)
    );

    // Sticky error flags: a new error in the same cycle as clear_flags stays set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_overflow  <= 1'b0;
            rx_underflow <= 1'b0;
        end else begin
            if (tx_push && (tx_count == FULL)) tx_overflow <= 1'b1;
            else if (clear_flags)              tx_overflow <= 1'b0;
            if (rx_pop && (rx_count == '0))    rx_underflow <= 1'b1;
            else if (clear_flags)              rx_underflow <= 1'b0;
        end
    end

    always_comb begin
        status               = '0;
        status[0]            = (tx_count != FULL);
        status[1]            = (rx_count != '0);
        status[2]            = tx_overflow;
        status[3]            = rx_underflow;
        status[8 +: AW+1]    = tx_count;
        status[16 +: AW+1]   = rx_count;
    end
endmodule

// File: tb/tb_uart_io_fifo.sv
// Self-checking bench for uart_io_fifo: directed steps plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_uart_io_fifo;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        loopback = 1'b0;
    logic        tx_push = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        rx_pop = 1'b0;
    logic [7:0]  rx_data;
    logic [31:0] status;
    logic        clear_flags = 1'b0;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready = 1'b0;
    logic [7:0]  uart_rx_data = 8'h00;
    logic        uart_rx_valid = 1'b0;
    logic        uart_rx_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] txq[$];
    logic [7:0] rxq[$];
    logic       m_ovf = 1'b0;
    logic       m_unf = 1'b0;

    always #5 clk = ~clk;

    uart_io_fifo #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef UART_IO_FIFO_LOOPBACK_EN
        .loopback      (loopback),
`endif
        .tx_push       (tx_push),
        .tx_data       (tx_data),
        .rx_pop        (rx_pop),
        .rx_data       (rx_data),
        .status        (status),
        .clear_flags   (clear_flags),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s        = '0;
        s[0]     = txq.size() < DEPTH;
        s[1]     = rxq.size() != 0;
        s[2]     = m_ovf;
        s[3]     = m_unf;
        s[11:8]  = 4'(txq.size());
        s[19:16] = 4'(rxq.size());
        return s;
    endfunction

    task automatic check_outputs();
        chk("status", status, exp_status());
        chk("tx_valid", uart_tx_valid, !loopback && txq.size() != 0);
        chk("rx_ready", uart_rx_ready, !loopback && rxq.size() < DEPTH);
        if (txq.size() != 0) chk("tx_data", uart_tx_data, txq[0]);
        if (rxq.size() != 0) chk("rx_data", rx_data, rxq[0]);
    endtask

    // Next state from the current inputs: every decision uses the occupancy seen before the edge.
    task automatic model_step();
        int ts = txq.size();
        int rs = rxq.size();
        logic tv, rr, lbm;
        tv  = !loopback && ts != 0;
        rr  = !loopback && rs < DEPTH;
        lbm = loopback && ts != 0 && rs < DEPTH;
        if (tx_push && ts == DEPTH) m_ovf = 1'b1;
        else if (clear_flags)       m_ovf = 1'b0;
        if (rx_pop && rs == 0)      m_unf = 1'b1;
        else if (clear_flags)       m_unf = 1'b0;
        if (rx_pop && rs != 0) void'(rxq.pop_front());
        if (lbm) rxq.push_back(txq.pop_front());
        else if (tv && uart_tx_ready) void'(txq.pop_front());
        if (tx_push && ts < DEPTH) txq.push_back(tx_data);
        if (uart_rx_valid && rr) rxq.push_back(uart_rx_data);
    endtask

    task automatic cycle();
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b0;
        txq.delete();
        rxq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        #1;
        chk("async_rst_tx_valid", uart_tx_valid, 1'b0);
        chk("async_rst_status", status, 32'h1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit slow;
        #2;
        chk("rst_status", status, 32'h1);
        chk("rst_tx_valid", uart_tx_valid, 1'b0);
        chk("rst_rx_ready", uart_rx_ready, 1'b1);
        chk("rst_rx_data", rx_data, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        repeat (2) cycle();

        // TX burst drained with the uart always ready
        uart_tx_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tx_push = 1'b1;
            tx_data = 8'(8'h41 + i);
            cycle();
        end
        tx_push = 1'b0;
        repeat (4) cycle();
        chk("tx_drained_count", status[15:8], 8'h00);

        // Overflow: nine pushes into an eight-entry queue with the uart stalled
        uart_tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tx_push = 1'b1;
            tx_data = 8'($urandom);
            cycle();
        end
        tx_push = 1'b0;
        cycle();
        chk("tx_full_count", status[11:8], 4'd8);
        chk("tx_full_ready", status[0], 1'b0);
        chk("tx_overflow", status[2], 1'b1);
        clear_flags = 1'b1;
        cycle();
        clear_flags = 1'b0;
        chk("tx_overflow_clr", status[2], 1'b0);
        uart_tx_ready = 1'b1;
        repeat (10) cycle();
        uart_tx_ready = 1'b0;

        // RX fill, backpressure on the ninth byte, then drain past empty
        for (int i = 0; i < 8; i++) begin
            uart_rx_valid = 1'b1;
            uart_rx_data  = 8'(8'h10 + i);
            cycle();
        end
        uart_rx_data = 8'h18;
        cycle();
        chk("rx_full_ready", uart_rx_ready, 1'b0);
        chk("rx_full_count", status[19:16], 4'd8);
        rx_pop = 1'b1;
        cycle();
        cycle();
        uart_rx_valid = 1'b0;
        repeat (8) cycle();
        rx_pop = 1'b0;
        chk("rx_underflow", status[3], 1'b1);
        chk("rx_empty_count", status[19:16], 4'd0);
        clear_flags = 1'b1;
        cycle();
        clear_flags = 1'b0;

        // Simultaneous push and pop at occupancy four
        for (int i = 0; i < 4; i++) begin
            tx_push = 1'b1;
            tx_data = 8'($urandom);
            cycle();
        end
        tx_push = 1'b0;
        cycle();
        tx_push = 1'b1;
        tx_data = 8'hC3;
        uart_tx_ready = 1'b1;
        cycle();
        tx_push = 1'b0;
        uart_tx_ready = 1'b0;
        chk("tx_pushpop_count", status[11:8], 4'd4);
        cycle();

        // Random traffic alternating between fast and slow drain phases
        for (int i = 0; i < 400; i++) begin
            slow          = ((i / 50) % 2) == 1;
            tx_push       = ($urandom % 2) == 1;
            tx_data       = 8'($urandom);
            uart_tx_ready = slow ? (($urandom % 4) == 0) : (($urandom % 4) != 0);
            uart_rx_valid = ($urandom % 2) == 1;
            uart_rx_data  = 8'($urandom);
            rx_pop        = slow ? (($urandom % 4) != 0) : (($urandom % 4) == 0);
            clear_flags   = ($urandom % 16) == 0;
            cycle();
        end
        tx_push = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        rx_pop = 1'b0;
        clear_flags = 1'b0;
        cycle();

        // Reset mid-stream with five bytes queued
        do_reset();
        for (int i = 0; i < 5; i++) begin
            tx_push = 1'b1;
            tx_data = 8'($urandom);
            cycle();
        end
        tx_push = 1'b0;
        cycle();
        chk("pre_rst_count", status[11:8], 4'd5);
        do_reset();
        cycle();
        chk("post_rst_status", status, 32'h1);

`ifdef UART_IO_FIFO_LOOPBACK_EN
        loopback = 1'b1;
        tx_push  = 1'b1;
        tx_data  = 8'h5A;
        cycle();
        tx_push = 1'b0;
        cycle();
        chk("lb_rx_data", rx_data, 8'h5A);
        chk("lb_tx_valid", uart_tx_valid, 1'b0);
        for (int i = 0; i < 300; i++) begin
            if ((i % 10) == 0) loopback = ($urandom % 2) == 1;
            tx_push       = ($urandom % 2) == 1;
            tx_data       = 8'($urandom);
            uart_tx_ready = ($urandom % 2) == 1;
            uart_rx_valid = ($urandom % 2) == 1;
            uart_rx_data  = 8'($urandom);
            rx_pop        = ($urandom % 3) == 0;
            clear_flags   = ($urandom % 16) == 0;
            cycle();
        end
        loopback = 1'b0;
        tx_push = 1'b0;
        uart_tx_ready = 1'b0;
        uart_rx_valid = 1'b0;
        rx_pop = 1'b0;
        clear_flags = 1'b0;
        cycle();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/uart_io_fifo.md
Name: uart_io_fifo

Overview:
- Buffered memory-mapped UART port between the CPU's IO space (0x8000_0000 region) and the on-chip uart transmitter and receiver.
- Provides a TX FIFO and an RX FIFO, so the core can burst stores to the TX data register and drain received bytes without polling per byte.
- Status bits keep the existing IO control word layout: bit0 = TX ready, bit1 = RX valid.

Parameters:
- DEPTH, 8: entries per FIFO; power of two, minimum 2.
- AW, $clog2(DEPTH): pointer width; occupancy counters are AW+1 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tx_push  in  1  CPU store to the TX data register (already qualified: not flushed, byte 0 enabled)
- tx_data  in  8  byte to enqueue
- rx_pop  in  1  CPU load from the RX data register (already qualified)
- rx_data  out  8  RX FIFO head
- status  out  32  IO control word
- clear_flags  in  1  clears sticky error flags
- uart_tx_data  out  8  to uart data_in
- uart_tx_valid  out  1  to uart data_in_valid
- uart_tx_ready  in  1  from uart data_in_ready
- uart_rx_data  in  8  from uart data_out
- uart_rx_valid  in  1  from uart data_out_valid
- uart_rx_ready  out  1  to uart data_out_ready

Behaviour:
- Reset (rst low, asynchronous assertion, deassertion taken on the clk edge):
  - Pointers and counts cleared; sticky flags cleared.
  - uart_tx_valid=0, uart_rx_ready=1, rx_data=0, status=0x0000_0001.
  - Storage contents need no reset.
  - Reset mid-transfer discards all queued bytes. The uart is reset separately and is not informed.
- TX FIFO:
  - Push: if tx_push and tx_count<DEPTH at the clock edge, write tx_data at wr_ptr and increment.
  - Push while full (judged on the registered count, even if a pop occurs the same cycle) is dropped and sets tx_overflow.
  - uart_tx_valid = (tx_count!=0), combinational from registered state. uart_tx_data = mem[rd_ptr].
  - Pop on uart_tx_valid && uart_tx_ready.
  - Simultaneous accepted push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo DEPTH.
- RX FIFO:
  - uart_rx_ready = (rx_count<DEPTH). Capture uart_rx_data on uart_rx_valid && uart_rx_ready.
  - rx_data = mem[rd_ptr] (first-word fall-through); valid in the same cycle the load is in its memory stage.
  - rx_pop with rx_count==0 is ignored and sets rx_underflow.
  - Simultaneous capture and pop are handled as in the TX FIFO.
  - The FIFO never drops a byte; backpressure holds the byte in the uart.
- Latency:
  - Pushed byte appears on uart_tx_valid the next cycle.
  - Captured byte is visible on rx_data and status[1] the next cycle.
- Status word (combinational from registers):
  - [0] tx_count<DEPTH
  - [1] rx_count!=0
  - [2] tx_overflow
  - [3] rx_underflow
  - [8 +: AW+1] tx_count
  - [16 +: AW+1] rx_count
  - all other bits 0
- Flags:
  - clear_flags zeroes both sticky flags.
  - If a set event and clear_flags occur in the same cycle, set wins.
- Counters never exceed DEPTH or go below 0 under any input combination.

Optional Feature:
- Macro: UART_IO_FIFO_LOOPBACK_EN.
- When defined, adds input port loopback (1 bit). While loopback=1:
  - The TX head is moved directly into the RX FIFO whenever tx_count!=0 and rx_count<DEPTH, one byte per cycle.
  - uart_tx_valid is forced to 0 and uart_rx_ready is forced to 0.
  - Toggling loopback never loses or duplicates a byte.
- When the macro is undefined: no loopback port, and behaviour is exactly as described above.

Test Plan:
- Reset, then idle: status==0x0000_0001, uart_tx_valid=0, uart_rx_ready=1.
- Push 0x41,0x42,0x43 with uart_tx_ready=1 -> uart_tx_data emits 0x41,0x42,0x43 on three consecutive handshakes; status[15:8] returns to 0.
- uart_tx_ready=0, push 9 bytes (DEPTH=8) -> status[11:8]==8, status[0]=0, status[2]=1. The 9th byte is never transmitted. clear_flags -> status[2]=0.
- Drive 8 RX bytes 0x10..0x17 with no pops -> uart_rx_ready drops after the 8th. A 9th byte held on uart_rx_valid is captured one cycle after the first rx_pop; pops return 0x10..0x17 then 0x18 in order.
- rx_pop on an empty RX FIFO -> status[3]=1, rx_count stays 0. Simultaneous push and pop at tx_count==4 -> count stays 4.
- Assert rst low mid-stream (tx_count=5) asynchronously -> uart_tx_valid=0 immediately; after release status==0x0000_0001. With the loopback macro defined and loopback=1, push 0x5A -> rx_data==0x5A two cycles later, uart_tx_valid stays 0.
